// File: rtl/obi_peripheral_responder.sv
// Single-outstanding OBI-style bus target: byte-writable scratch registers,
// a read-only cycle counter and a fixed pattern for unmapped words.
module obi_peripheral_responder #(
    parameter int unsigned NUM_REGS      = 16,
    parameter int unsigned WAIT_CYCLES   = 0,
    parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [23:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] ctrl_o
);

    localparam int unsigned REG_AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [2:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q;
    logic [2:0]         wait_q;
    logic [31:0]        rdata_q;
    logic [31:0]        cnt_q;
    logic [31:0]        regs_q [NUM_REGS];

    logic [21:0]        word_idx;
    logic [REG_AW-1:0]  reg_idx;
    logic               is_reg;
    logic               is_cnt;
    logic               accept;
    logic [31:0]        rd_word;
    logic               unused_addr;

    assign word_idx    = addr_i[23:2];
    assign reg_idx     = word_idx[REG_AW-1:0];
    assign is_reg      = word_idx < 22'(NUM_REGS);
    assign is_cnt      = word_idx == 22'(NUM_REGS);
    assign unused_addr = ^addr_i[1:0];

    // Grant depends on state alone so the initiator never sees a REQ->GNT loop.
    assign gnt_o    = (state_q == S_IDLE);
    assign accept   = req_i && gnt_o;
    assign rvalid_o = (state_q == S_RESP);
    assign rdata_o  = rvalid_o ? rdata_q : 32'h0;
    assign ctrl_o   = regs_q[0];

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        rd_word = UNMAPPED_DATA;
        if (is_reg) begin
            rd_word = regs_q[reg_idx];
        end else if (is_cnt) begin
            rd_word = cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wait_q  <= 3'd0;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                        wait_q  <= WAIT_LOAD;
                        rdata_q <= we_i ? 32'h0 : rd_word;
                    end
                end
                S_WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // NOTE: the register bank is reset explicitly; software relies on a zeroed CTRL and scratch area.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else if (accept && we_i && is_reg) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_idx == REG_AW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_i[b]) begin
                            regs_q[i][8*b +: 8] <= wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_obi_peripheral_responder.sv
// Directed bench: one responder with zero wait cycles, one with three,
// each driven through its own port set on a shared clock.
module tb_obi_peripheral_responder;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [23:0] addr  [2];
    logic [31:0] wdata [2];
    logic        gnt   [2];
    logic        rvalid[2];
    logic [31:0] rdata [2];
    logic [31:0] ctrl  [2];

    int  n_vec  = 0;
    int  n_miss = 0;
    time t_rel;

    always #5 clk = ~clk;

    obi_peripheral_responder #(.NUM_REGS(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .ctrl_o(ctrl[0])
    );

    obi_peripheral_responder #(.NUM_REGS(16), .WAIT_CYCLES(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .ctrl_o(ctrl[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction; inputs are scrambled right after acceptance.
    task automatic xact(input int d, input logic w, input logic [3:0] b, input logic [23:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output time t_acc);
        int lat;
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        check({tag, "_gnt"}, {31'b0, gnt[d]}, 32'd1);
        @(posedge clk);
        t_acc = $time;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req[d] = 1'b0; addr[d] = 24'h00000C; wdata[d] = 32'hFFFF_FFFF; be[d] = 4'hF;
            end
        end while (!rvalid[d] && lat < 20);
        check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        rd = rdata[d];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, c1, c2;
        time t1, t2;
        int seen;

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
            addr[d] = 24'h0; wdata[d] = 32'h0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst_gnt",    {31'b0, gnt[d]},    32'd1);
            check("rst_rvalid", {31'b0, rvalid[d]}, 32'd0);
            check("rst_rdata",  rdata[d],           32'h0);
            check("rst_ctrl",   ctrl[d],            32'h0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        t_rel = $time;

        // Write then read back, zero wait cycles
        xact(0, 1'b1, 4'hF, 24'h000004, 32'h1234_5678, "wr1", rd, t1);
        check("wr1_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'hF, 24'h000004, 32'h0, "rd1", rd, t1);
        check("rd1_rdata", rd, 32'h1234_5678);

        // Byte enables on register 2
        xact(0, 1'b1, 4'hF, 24'h000008, 32'hAABB_CCDD, "pre2", rd, t1);
        xact(0, 1'b1, 4'h5, 24'h000008, 32'h1122_3344, "be5", rd, t1);
        xact(0, 1'b0, 4'hF, 24'h000008, 32'h0, "rd2a", rd, t1);
        check("be_merge", rd, 32'hAA22_CC44);
        xact(0, 1'b1, 4'h0, 24'h000008, 32'h5555_5555, "be0", rd, t1);
        xact(0, 1'b0, 4'hF, 24'h000008, 32'h0, "rd2b", rd, t1);
        check("be_none", rd, 32'hAA22_CC44);

        // Unmapped read, read-only counter
        xact(0, 1'b0, 4'hF, 24'h000100, 32'h0, "unm", rd, t1);
        check("unmapped_rd", rd, 32'hDEAD_BEEF);
        xact(0, 1'b1, 4'hF, 24'h000040, 32'hFFFF_FFFF, "cntwr", rd, t1);
        check("cntwr_rdata", rd, 32'h0);
        xact(0, 1'b0, 4'hF, 24'h000040, 32'h0, "cnt1", c1, t1);
        check("cnt_abs", c1, 32'((t1 - t_rel - 5) / 10));
        repeat (5) @(negedge clk);
        xact(0, 1'b0, 4'hF, 24'h000040, 32'h0, "cnt2", c2, t2);
        check("cnt_delta", c2 - c1, 32'd7);

        // Inputs changed after acceptance must not leak into the write
        xact(0, 1'b1, 4'hF, 24'h000004, 32'h0BAD_F00D, "stab", rd, t1);
        xact(0, 1'b0, 4'hF, 24'h000004, 32'h0, "rd1s", rd, t1);
        check("stab_reg1", rd, 32'h0BAD_F00D);
        xact(0, 1'b0, 4'hF, 24'h00000C, 32'h0, "rd3", rd, t1);
        check("stab_reg3", rd, 32'h0);
        xact(0, 1'b0, 4'hF, 24'h000008, 32'h0, "rd2c", rd, t1);
        check("stab_reg2", rd, 32'hAA22_CC44);
        check("stab_ctrl", ctrl[0], 32'h0);

        // Three wait cycles: REQ held high for three reads of register 5
        xact(1, 1'b1, 4'hF, 24'h000014, 32'h5A5A_0001, "pre5", rd, t1);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 24'h000014; wdata[1] = 32'h0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            check("lat_gnt",    {31'b0, gnt[1]},    (c % 5 == 0) ? 32'd1 : 32'd0);
            check("lat_rvalid", {31'b0, rvalid[1]}, (c % 5 == 4) ? 32'd1 : 32'd0);
            if (c % 5 == 4) check("lat_rdata", rdata[1], 32'h5A5A_0001);
            if (c == 2)     check("lat_rdata_idle", rdata[1], 32'h0);
            if (c == 14)    req[1] = 1'b0;
        end

        // Reset while a write response is pending
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 24'h000000; wdata[1] = 32'hCAFE_0000;
        check("mrst_gnt_pre", {31'b0, gnt[1]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        check("mrst_ctrl_pre", ctrl[1], 32'hCAFE_0000);
        check("mrst_busy", {31'b0, gnt[1]}, 32'd0);
        @(posedge clk);
        #2 rst_n[1] = 1'b0;
        #1;
        check("mrst_gnt",    {31'b0, gnt[1]},    32'd1);
        check("mrst_rvalid", {31'b0, rvalid[1]}, 32'd0);
        check("mrst_ctrl",   ctrl[1],            32'h0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rvalid[1]) seen++;
        end
        check("mrst_no_resp", 32'(seen), 32'd0);
        xact(1, 1'b0, 4'hF, 24'h000000, 32'h0, "mrst_rd", rd, t1);
        check("mrst_reg0", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
